// File: rtl/kpyd_pkg.sv
// Keypad scanner shared types, constants and row-decode helpers.
// Build option KPYD_GHOST_REJECT_EN is consumed by kpyd_scanner.
package kpyd_pkg;

   localparam int unsigned KPYD_ROWS = 4;
   localparam int unsigned KPYD_COLS = 4;

   typedef enum logic [1:0] {
      SCAN,
      CONFIRM,
      HELD,
      RELEASE
   } kpyd_state_e;

   typedef logic [3:0] key_code_t;

   // Index of the lowest-numbered row that is pulled low.
   function automatic logic [1:0] lowest_low(input logic [KPYD_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = KPYD_ROWS; i > 0; i--) begin
         if (!rows[i-1]) idx = 2'(i - 1);
      end
      return idx;
   endfunction

   // True when two or more rows are low at once.
   function automatic logic multi_low(input logic [KPYD_ROWS-1:0] rows);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < KPYD_ROWS; i++) begin
         if (!rows[i]) n++;
      end
      return (n > 1);
   endfunction

endpackage

// File: rtl/kpyd_sync.sv
// Two-flop synchronizer, async active-low reset to all-ones (idle rows).
module kpyd_sync #(
   parameter int unsigned width_p = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [width_p-1:0] d,
   output logic [width_p-1:0] q
);

   logic [width_p-1:0] meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/kpyd_scanner.sv
// 4x4 keypad scanner and debouncer.
// Build option: KPYD_GHOST_REJECT_EN rejects samples with more than one
// row low (in SCAN) and aborts confirmation on a second low row.
module kpyd_scanner
   import kpyd_pkg::*;
#(
   parameter int unsigned debounce_cycles_p = 16,
   parameter int unsigned scan_cycles_p     = 4
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic       debounce_o,
   output logic [3:0] key_o
);

   localparam int unsigned CNT_W = $clog2(debounce_cycles_p);
   localparam int unsigned DW_W  = $clog2(scan_cycles_p);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles_p - 1);
   localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(scan_cycles_p - 1);

   logic [3:0]       row_s;
   kpyd_state_e      state_r, state_n;
   logic [1:0]       col_r, col_n;
   logic [1:0]       row_r, row_n;
   logic [DW_W-1:0]  dwell_r, dwell_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;
   logic             deb_r, deb_n;
   key_code_t        key_r, key_n;
   logic             row_hit;
   logic             many_low;
   logic             key_seen;

   kpyd_sync #(.width_p(KPYD_ROWS)) u_sync (
      .clk   (clk_i),
      .rst_n (reset_n_i),
      .d     (row_i),
      .q     (row_s)
   );

   assign col_o      = ~(4'b0001 << col_r);
   assign debounce_o = deb_r;
   assign key_o      = key_r;

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= SCAN;
         col_r   <= '0;
         row_r   <= '0;
         dwell_r <= '0;
         cnt_r   <= '0;
         deb_r   <= 1'b0;
         key_r   <= '0;
      end else begin
         state_r <= state_n;
         col_r   <= col_n;
         row_r   <= row_n;
         dwell_r <= dwell_n;
         cnt_r   <= cnt_n;
         deb_r   <= deb_n;
         key_r   <= key_n;
      end
   end

   // Next-state: scan columns, then debounce press and release on the captured row.
   always_comb begin
      state_n  = state_r;
      col_n    = col_r;
      row_n    = row_r;
      dwell_n  = dwell_r;
      cnt_n    = cnt_r;
      deb_n    = deb_r;
      key_n    = key_r;
      row_hit  = ~row_s[row_r];
      many_low = multi_low(row_s);
`ifdef KPYD_GHOST_REJECT_EN
      key_seen = ~&row_s && !many_low;
`else
      key_seen = ~&row_s;
`endif
      case (state_r)
         SCAN: begin
            if (dwell_r == DW_LAST) begin
               dwell_n = '0;
               if (key_seen) begin
                  row_n   = lowest_low(row_s);
                  cnt_n   = '0;
                  state_n = CONFIRM;
               end else begin
                  col_n = col_r + 2'd1;
               end
            end else begin
               dwell_n = dwell_r + DW_W'(1);
            end
         end
         CONFIRM: begin
`ifdef KPYD_GHOST_REJECT_EN
            if (many_low) begin
               dwell_n = '0;
               state_n = SCAN;
            end else
`endif
            if (row_hit) begin
               if (cnt_r == CNT_LAST) begin
                  state_n = HELD;
                  deb_n   = 1'b1;
                  key_n   = {row_r, col_r};
               end else begin
                  cnt_n = cnt_r + CNT_W'(1);
               end
            end else begin
               dwell_n = '0;
               state_n = SCAN;
            end
         end
         HELD: begin
            if (!row_hit) begin
               cnt_n   = '0;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            if (!row_hit) begin
               if (cnt_r == CNT_LAST) begin
                  state_n = SCAN;
                  deb_n   = 1'b0;
                  col_n   = col_r + 2'd1;
                  dwell_n = '0;
               end else begin
                  cnt_n = cnt_r + CNT_W'(1);
               end
            end else begin
               state_n = HELD;
            end
         end
         default: state_n = SCAN;
      endcase
   end

endmodule

// File: tb/tb_kpyd_scanner.sv
// Directed bench for kpyd_scanner with a keypad model driving rows from columns.
module tb_kpyd_scanner;

   logic        clk;
   logic        reset_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        deb;
   logic [3:0]  key;
   logic [15:0] mask;

   int unsigned n_checks;
   int unsigned n_pass;

   typedef struct {
      logic [15:0] mask;
      int unsigned cycles;
      logic [3:0]  col;
      logic        deb;
      logic [3:0]  key;
   } vec_t;

   vec_t vecs[20];

   kpyd_scanner #(.debounce_cycles_p(4), .scan_cycles_p(4)) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n),
      .row_i      (row),
      .col_o      (col),
      .debounce_o (deb),
      .key_o      (key)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Keypad model: a pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mask     = '0;
      reset_n  = 1'b0;

      vecs[0]  = '{16'h0000, 3,  4'b1110, 1'b0, 4'd0};
      vecs[1]  = '{16'h0000, 1,  4'b1101, 1'b0, 4'd0};
      vecs[2]  = '{16'h0000, 4,  4'b1011, 1'b0, 4'd0};
      vecs[3]  = '{16'h0000, 4,  4'b0111, 1'b0, 4'd0};
      vecs[4]  = '{16'h0000, 4,  4'b1110, 1'b0, 4'd0};
      vecs[5]  = '{16'h0200, 4,  4'b1101, 1'b0, 4'd0};
      vecs[6]  = '{16'h0200, 7,  4'b1101, 1'b0, 4'd0};
      vecs[7]  = '{16'h0200, 1,  4'b1101, 1'b1, 4'd9};
      vecs[8]  = '{16'h0200, 20, 4'b1101, 1'b1, 4'd9};
      vecs[9]  = '{16'h0000, 6,  4'b1101, 1'b1, 4'd9};
      vecs[10] = '{16'h0000, 1,  4'b1011, 1'b0, 4'd9};
      vecs[11] = '{16'h0004, 4,  4'b1011, 1'b0, 4'd9};
      vecs[12] = '{16'h0000, 1,  4'b1011, 1'b0, 4'd9};
      vecs[13] = '{16'h0004, 2,  4'b1011, 1'b0, 4'd9};
      vecs[14] = '{16'h0004, 7,  4'b1011, 1'b0, 4'd9};
      vecs[15] = '{16'h0004, 1,  4'b1011, 1'b1, 4'd2};
      vecs[16] = '{16'h0000, 2,  4'b1011, 1'b1, 4'd2};
      vecs[17] = '{16'h0004, 3,  4'b1011, 1'b1, 4'd2};
      vecs[18] = '{16'h0000, 6,  4'b1011, 1'b1, 4'd2};
      vecs[19] = '{16'h0000, 1,  4'b0111, 1'b0, 4'd2};

      // Reset state while held in reset
      step(3);
      check("reset_col", col, 4'b1110);
      check("reset_deb", {3'b000, deb}, 4'd0);
      check("reset_key", key, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Scan stepping, clean press/release, press bounce, release bounce
      for (int i = 0; i < 20; i++) begin
         mask = vecs[i].mask;
         step(vecs[i].cycles);
         check($sformatf("vec%0d_col", i), col, vecs[i].col);
         check($sformatf("vec%0d_deb", i), {3'b000, deb}, {3'b000, vecs[i].deb});
         check($sformatf("vec%0d_key", i), key, vecs[i].key);
      end

      // Rows 1 and 3 low on column 0
      mask = 16'h1010;
      step(11);
`ifdef KPYD_GHOST_REJECT_EN
      check("ghost_col_a", col, 4'b1101);
`else
      check("ghost_col_a", col, 4'b1110);
`endif
      check("ghost_deb_a", {3'b000, deb}, 4'd0);
      step(1);
`ifdef KPYD_GHOST_REJECT_EN
      check("ghost_col_b", col, 4'b1011);
      check("ghost_deb_b", {3'b000, deb}, 4'd0);
      check("ghost_key_b", key, 4'd2);
`else
      check("ghost_col_b", col, 4'b1110);
      check("ghost_deb_b", {3'b000, deb}, 4'd1);
      check("ghost_key_b", key, 4'd4);
`endif

      // Async reset mid-operation, then again while a key is held
      mask = '0;
      reset_n = 1'b0;
      #2;
      check("areset1_deb", {3'b000, deb}, 4'd0);
      check("areset1_col", col, 4'b1110);
      check("areset1_key", key, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mask = 16'h0200;
      for (int i = 0; i < 60 && deb !== 1'b1; i++) step(1);
      check("held_deb", {3'b000, deb}, 4'd1);
      check("held_key", key, 4'd9);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset2_deb", {3'b000, deb}, 4'd0);
      check("areset2_col", col, 4'b1110);
      check("areset2_key", key, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kpyd_scanner.md
# kpyd_scanner

4x4 matrix keypad scanner and debouncer, directly upstream of the keypad edge detector. Drives keypad columns one at a time, samples the rows through a synchronizer, and confirms a press or release only after it is stable for a programmable number of cycles. Produces a clean, debounced key-held level `debounce_o` (fed straight into the edge detector's `debounce_i`) and a 4-bit key code `key_o`.

## Interface
- `debounce_cycles_p`, default 16: consecutive stable cycles required to confirm a press or a release; must be ≥2.
- `scan_cycles_p`, default 4: dwell cycles per column; must be ≥3 to cover synchronizer latency.
- `clk_i`  in  1  single clock; all state on rising edge.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `row_i`  in  4  keypad rows, active-low (pulled up), asynchronous to `clk_i`.
- `col_o`  out  4  keypad column drive, active-low one-hot.
- `debounce_o`  out  1  high while a confirmed key is held.
- `key_o`  out  4  code of last confirmed key = row*4 + col.

## Operation
- `row_i` passes through a 2-flop synchronizer (reset 4'b1111); all decisions use the synchronized value `row_s`.
- Column index `col_r` (2 bits) selects `col_o = ~(1 << col_r)`. Dwell counter `dwell_r` counts 0..`scan_cycles_p`-1.
- States:
  - SCAN: `dwell_r` increments. At `dwell_r == scan_cycles_p-1`, if any `row_s` bit is 0: capture the lowest-index low row into `row_r`, keep `col_r`, clear counter, go CONFIRM. Otherwise wrap `dwell_r` to 0 and advance `col_r` (3 wraps to 0).
  - CONFIRM: column frozen. If `row_s[row_r]==0`, increment `cnt_r`; at `cnt_r == debounce_cycles_p-1` go HELD, set `debounce_o`=1, and load `key_o = {row_r, col_r}`. If `row_s[row_r]==1`, go SCAN with `dwell_r`=0, same column.
  - HELD: `debounce_o`=1. When `row_s[row_r]==1`, clear `cnt_r` and go RELEASE.
  - RELEASE: `debounce_o` stays 1. If `row_s[row_r]==1`, increment `cnt_r`; at `debounce_cycles_p-1`, go SCAN, clear `debounce_o`, advance `col_r`, `dwell_r`=0. If `row_s[row_r]==0`, go back to HELD.
- `key_o` changes only on entry to HELD; it holds its value after release.
- Rows other than `row_r` are ignored outside SCAN. A second key pressed while HELD is not reported.

## Timing
- Reset values: `col_o`=4'b1110, `debounce_o`=0, `key_o`=4'd0, state SCAN, all counters 0.
- `debounce_o` and `key_o` are registered and change together. `debounce_o` rises exactly `debounce_cycles_p` cycles after entry to CONFIRM, provided the row stays low.
- Press latency from pin to `debounce_o`: 2 (sync) + up to 4·`scan_cycles_p` + `debounce_cycles_p` cycles.
- `debounce_o` falls `debounce_cycles_p` cycles after entry to RELEASE, provided the row stays high.
- Any single-cycle bounce resets confirmation; the counter never saturates past the threshold.
- Asserting `reset_n_i` mid-operation forces all outputs to their reset values immediately (asynchronously).

## Configuration
- `KPYD_GHOST_REJECT_EN` defined: in SCAN, a sample with more than one `row_s` bit low is treated as no key, and scanning continues. In CONFIRM, a second low row aborts the confirmation and returns to SCAN.
- `KPYD_GHOST_REJECT_EN` undefined: the lowest-index low row wins, and other rows are ignored.

## Structure
- Package `kpyd_pkg` holds:
  - state enum `kpyd_state_e` (SCAN, CONFIRM, HELD, RELEASE);
  - `typedef logic [3:0] key_code_t`;
  - constants `KPYD_ROWS=4`, `KPYD_COLS=4`.
- Sub-module `kpyd_sync`: parameterized-width 2-flop synchronizer with async active-low reset and reset value all-ones.

## Test plan
All scenarios use `debounce_cycles_p`=4 and `scan_cycles_p`=4; the model drives `row_i` from `col_o`.
- Reset: hold `reset_n_i` low → `col_o`=1110, `debounce_o`=0, `key_o`=0. After release, `col_o` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Clean press of row 2, col 1 for 40 cycles → `col_o` freezes at 1101, `debounce_o` rises 4 cycles after CONFIRM entry, `key_o`=4'd9. After release, `debounce_o` falls 4 cycles after RELEASE entry, and `key_o` stays 9.
- Press bounce: row low, then high for 1 cycle during CONFIRM (`cnt_r`=2) → return to SCAN, `debounce_o` never asserts.
- Release bounce: row high 2 cycles, then low, then stable high → `debounce_o` stays 1 throughout the bounce and falls only after 4 consecutive high cycles.
- Two rows (1 and 3) low on col 0: without macro → `key_o`=4'd4; with `KPYD_GHOST_REJECT_EN` → no detection, and scanning continues.
- Async reset asserted in HELD → `debounce_o`=0 and `col_o`=1110 in the same cycle, before the next clock edge.
